// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared arbiter state encoding and byte-lane constants.
// Revision : 1.0
// ============================================================================
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } arb_state_t;

  localparam logic [3:0] BYTEEN_ALL  = 4'b1111;
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_mem_arbiter
// Purpose  : Sequences one shared bus between the CPU fetch and data ports and
//            releases one CPU clock-enable pulse per completed instruction.
// Revision : 1.0
// ============================================================================
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        cpu_clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_is_write;
  logic [31:0] r_instr;
  logic [31:0] r_data;

  // The reset vector is informational; the CPU owns its own PC.
  logic w_unused_reset_vector;
  assign w_unused_reset_vector = ^RESET_VECTOR;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (!bus_waitrequest) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (data_read || data_write) begin
          w_next_state = ST_DATA;
        end else begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_DATA: begin
        if (!bus_waitrequest) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_next_state = cpu_active ? ST_FETCH : ST_HALT;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // Write wins when the CPU raises both requests; the choice is frozen in
  // DECODE so the strobe cannot change while the bus is stalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= '0;
      r_data     <= '0;
      r_is_write <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!bus_waitrequest) begin
            r_instr <= bus_readdata;
          end
        end
        ST_DECODE: begin
          r_is_write <= data_write;
        end
        ST_DATA: begin
          if (!bus_waitrequest && !r_is_write) begin
            r_data <= bus_readdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign instr_readdata = r_instr;
  assign data_readdata  = r_data;

  // Outputs are forced low while reset is held so an abandoned transfer
  // drops its strobes immediately.
  always_comb begin
    bus_address    = '0;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_byteenable = BYTEEN_NONE;
    bus_writedata  = '0;
    cpu_clk_enable = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          bus_address    = instr_address;
          bus_read       = 1'b1;
          bus_byteenable = BYTEEN_ALL;
        end
        ST_DATA: begin
          bus_address    = data_address;
          bus_byteenable = BYTEEN_ALL;
          if (r_is_write) begin
            bus_write     = 1'b1;
            bus_writedata = data_writedata;
          end else begin
            bus_read = 1'b1;
          end
        end
        ST_COMMIT: begin
          cpu_clk_enable = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule : mips_cpu_mem_arbiter
`default_nettype wire
